// File: rtl/pea_firing_scheduler.sv
// pea_firing_scheduler: autonomous CFDF firing sequencer for the PEA actor.
// Steps next_mode through SETUP_INSTR -> INSTR -> OUTPUT. Each mode waits for
// enable, issues one invoke and waits for fc. After OUTPUT it pops one
// result/status pair from the output FIFOs. All outputs are decoded from
// registered state only.
module pea_firing_scheduler #(
   parameter int unsigned OUT_WIDTH   = 32,
   parameter int unsigned STALL_LIMIT = 64,
   parameter int unsigned FC_TIMEOUT  = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 loop,
   input  logic                 clear,
   input  logic                 enable,
   input  logic                 fc,
   input  logic [OUT_WIDTH-1:0] result_in,
   input  logic [OUT_WIDTH-1:0] status_in,
   output logic [1:0]           next_mode_out,
   output logic                 invoke,
   output logic                 rd_en_result,
   output logic                 rd_en_status,
   output logic [OUT_WIDTH-1:0] result_q,
   output logic [OUT_WIDTH-1:0] status_q,
   output logic                 done,
   output logic                 busy,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [15:0]          pass_count
);

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StInvoke,
      StWaitFc,
      StRead,
      StCapture,
      StError
   } state_e;

   localparam logic [1:0]  ModeSetup   = 2'b00;
   localparam logic [1:0]  ModeOutput  = 2'b10;
   localparam logic [1:0]  CodeNone    = 2'b00;
   localparam logic [1:0]  CodeStall   = 2'b01;
   localparam logic [1:0]  CodeTimeout = 2'b10;
   localparam logic [15:0] StallLast   = 16'(STALL_LIMIT - 1);
   localparam logic [15:0] FcLast      = 16'(FC_TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [15:0]          cnt_inc;
   logic [1:0]           err_code_q, err_code_d;
   logic [15:0]          pass_count_q, pass_count_d;
   logic [OUT_WIDTH-1:0] result_d, status_d;

   // Saturating increment shared by the enable-stall and fc-timeout waits.
   always_comb begin
      cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   end

   // Next-state logic: firing sequence, wait counters, capture and error latching.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      cnt_d        = cnt_q;
      err_code_d   = err_code_q;
      pass_count_d = pass_count_q;
      result_d     = result_q;
      status_d     = status_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCheck;
               mode_d  = ModeSetup;
               cnt_d   = '0;
            end
         end
         StCheck: begin
            if (enable) begin
               state_d = StInvoke;
               cnt_d   = '0;
            end else if (cnt_q >= StallLast) begin
               state_d    = StError;
               err_code_d = CodeStall;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StInvoke: begin
            state_d = StWaitFc;
            cnt_d   = '0;
         end
         StWaitFc: begin
            if (fc) begin
               if (mode_q == ModeOutput) begin
                  state_d = StRead;
               end else begin
                  state_d = StCheck;
                  mode_d  = mode_q + 2'd1;
                  cnt_d   = '0;
               end
            end else if (cnt_q >= FcLast) begin
               state_d    = StError;
               err_code_d = CodeTimeout;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StRead: begin
            state_d = StCapture;
         end
         StCapture: begin
            // FIFO data is valid the cycle after the pop issued in StRead.
            result_d     = result_in;
            status_d     = status_in;
            pass_count_d = pass_count_q + 16'd1;
            mode_d       = ModeSetup;
            cnt_d        = '0;
            state_d      = loop ? StCheck : StIdle;
         end
         StError: begin
            // mode_q is left untouched so the failing mode stays visible.
            if (clear) begin
               state_d    = StIdle;
               err_code_d = CodeNone;
               mode_d     = ModeSetup;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         mode_q       <= ModeSetup;
         cnt_q        <= '0;
         err_code_q   <= CodeNone;
         pass_count_q <= '0;
         result_q     <= '0;
         status_q     <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         err_code_q   <= err_code_d;
         pass_count_q <= pass_count_d;
         result_q     <= result_d;
         status_q     <= status_d;
      end
   end

   // Moore output decode from the registered state.
   always_comb begin
      next_mode_out = mode_q;
      invoke        = (state_q == StInvoke);
      rd_en_result  = (state_q == StRead);
      rd_en_status  = (state_q == StRead);
      done          = (state_q == StCapture);
      busy          = (state_q != StIdle) && (state_q != StError);
      err           = (state_q == StError);
      err_code      = err_code_q;
      pass_count    = pass_count_q;
   end

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Bench for pea_firing_scheduler. Each scenario is described as a timeline
// of protocol phases (idle, check, invoke, wait, read, capture, error). Each
// phase entry carries the stimulus for that cycle and the outputs it implies.
// The timeline is then played against the DUT and compared cycle by cycle.
module tb_pea_firing_scheduler;

   localparam int unsigned OW = 32;

   logic          clk = 1'b1;
   logic          rst, start, loop, clear, enable, fc;
   logic [OW-1:0] result_in, status_in;
   logic [1:0]    next_mode_out;
   logic          invoke, rd_en_result, rd_en_status, done, busy, err;
   logic [OW-1:0] result_q, status_q;
   logic [1:0]    err_code;
   logic [15:0]   pass_count;

   always #5 clk = ~clk;

   pea_firing_scheduler #(
      .OUT_WIDTH  (OW),
      .STALL_LIMIT(8),
      .FC_TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .loop         (loop),
      .clear        (clear),
      .enable       (enable),
      .fc           (fc),
      .result_in    (result_in),
      .status_in    (status_in),
      .next_mode_out(next_mode_out),
      .invoke       (invoke),
      .rd_en_result (rd_en_result),
      .rd_en_status (rd_en_status),
      .result_q     (result_q),
      .status_q     (status_q),
      .done         (done),
      .busy         (busy),
      .err          (err),
      .err_code     (err_code),
      .pass_count   (pass_count)
   );

   typedef struct {
      logic        chk;
      logic        rst, start, loop, clear, enable, fc;
      logic [31:0] rin, sin;
      logic [1:0]  mode;
      logic        inv, rd, done, busy, err;
      logic [1:0]  code;
      logic [31:0] rq, sq;
      logic [15:0] pc;
   } step_t;

   step_t       tl[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          step_no = 0;
   int          n_inv, n_rd, n_done;
   // Expected registered values and current FIFO/loop stimulus.
   logic [31:0] m_rq = 0, m_sq = 0;
   logic [15:0] m_pc = 0;
   logic [31:0] s_rin = 0, s_sin = 0;
   logic        s_loop = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at step %0d: got %h, expected %h", nm, step_no, act, exp);
      end
   endfunction

   function automatic void push(logic r, logic st, logic cl, logic en, logic f,
                                logic [1:0] md, logic iv, logic rd, logic dn,
                                logic bz, logic er, logic [1:0] cd);
      step_t s;
      s.chk = 1'b1;   s.rst = r;     s.start = st;  s.loop = s_loop;
      s.clear = cl;   s.enable = en; s.fc = f;
      s.rin = s_rin;  s.sin = s_sin;
      s.mode = md;    s.inv = iv;    s.rd = rd;     s.done = dn;
      s.busy = bz;    s.err = er;    s.code = cd;
      s.rq = m_rq;    s.sq = m_sq;   s.pc = m_pc;
      tl.push_back(s);
   endfunction

   function automatic void e_idle(logic st);
      push(0, st, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
   endfunction

   // junk=1 drives start, clear and fc in phases where they must be ignored.
   function automatic void e_check(logic [1:0] m, logic en, logic junk);
      push(0, junk, junk, en, junk, m, 0, 0, 0, 1, 0, 2'd0);
   endfunction

   function automatic void e_error(logic [1:0] m, logic [1:0] cd, logic cl);
      push(0, 1, cl, 1, 1, m, 0, 0, 0, 0, 1, cd);
   endfunction

   // One full pass: d stalled CHECK cycles per mode, fc on the f-th WAIT_FC cycle.
   function automatic void e_pass(int d, int f, logic junk);
      for (int m = 0; m < 3; m++) begin
         for (int j = 0; j < d; j++) e_check(2'(m), 0, junk);
         e_check(2'(m), 1, junk);
         push(0, junk, 0, junk, junk, 2'(m), 1, 0, 0, 1, 0, 2'd0);
         for (int j = 1; j <= f; j++)
            push(0, 0, 0, 0, (j == f), 2'(m), 0, 0, 0, 1, 0, 2'd0);
      end
      push(0, 0, 0, 0, 0, 2'd2, 0, 1, 0, 1, 0, 2'd0);
      push(0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 1, 0, 2'd0);
      m_rq = s_rin;
      m_sq = s_sin;
      m_pc = m_pc + 16'd1;
   endfunction

   // Play the timeline: compare outputs of the cycle, then drive its inputs.
   task automatic run_seg();
      n_inv = 0; n_rd = 0; n_done = 0;
      foreach (tl[i]) begin
         @(negedge clk);
         step_no++;
         if (tl[i].chk) begin
            chk("next_mode_out", 32'(next_mode_out), 32'(tl[i].mode));
            chk("invoke",        32'(invoke),        32'(tl[i].inv));
            chk("rd_en_result",  32'(rd_en_result),  32'(tl[i].rd));
            chk("rd_en_status",  32'(rd_en_status),  32'(tl[i].rd));
            chk("done",          32'(done),          32'(tl[i].done));
            chk("busy",          32'(busy),          32'(tl[i].busy));
            chk("err",           32'(err),           32'(tl[i].err));
            chk("err_code",      32'(err_code),      32'(tl[i].code));
            chk("result_q",      result_q,           tl[i].rq);
            chk("status_q",      status_q,           tl[i].sq);
            chk("pass_count",    32'(pass_count),    32'(tl[i].pc));
         end
         if (invoke === 1'b1) n_inv++;
         if (rd_en_result === 1'b1) n_rd++;
         if (done === 1'b1) n_done++;
         rst       = tl[i].rst;
         start     = tl[i].start;
         loop      = tl[i].loop;
         clear     = tl[i].clear;
         enable    = tl[i].enable;
         fc        = tl[i].fc;
         result_in = tl[i].rin;
         status_in = tl[i].sin;
      end
      tl.delete();
   endtask

   initial begin
      step_t s0;
      rst = 1; start = 0; loop = 0; clear = 0; enable = 0; fc = 0;
      result_in = '0; status_in = '0;

      // Power-on reset; the first cycle precedes any edge so it is not checked.
      push(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
      s0 = tl[0]; s0.chk = 1'b0; tl[0] = s0;
      push(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);

      // Single pass, fc three cycles after each invoke.
      s_rin = 32'h0000_1234; s_sin = 32'h0000_0001;
      e_idle(0); e_idle(1);
      e_pass(0, 3, 0);
      e_idle(0); e_idle(0); e_idle(0);
      run_seg();
      chk("single_invokes", n_inv, 3);
      chk("single_reads", n_rd, 1);
      chk("single_done", n_done, 1);
      chk("single_result", result_q, 32'h0000_1234);
      chk("single_status", status_q, 32'h0000_0001);
      chk("single_count", 32'(pass_count), 1);

      // Enable stall: eight CHECK cycles, then ERROR until clear.
      e_idle(1);
      for (int j = 0; j < 8; j++) e_check(2'd0, 0, 1);
      e_error(2'd0, 2'b01, 0); e_error(2'd0, 2'b01, 0); e_error(2'd0, 2'b01, 1);
      e_idle(0); e_idle(0);
      run_seg();
      chk("stall_invokes", n_inv, 0);
      chk("stall_cleared_err", 32'(err), 0);

      // Late enable: five stalled cycles in every mode stays below the limit.
      s_rin = 32'h0000_0055; s_sin = 32'h0000_0002;
      e_idle(1);
      e_pass(5, 3, 0);
      e_idle(0); e_idle(0);
      run_seg();
      chk("late_err", 32'(err), 0);
      chk("late_count", 32'(pass_count), 2);

      // fc timeout: one invoke, sixteen WAIT_FC cycles, no pops.
      e_idle(1);
      e_check(2'd0, 1, 0);
      push(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 1, 0, 2'd0);
      for (int j = 0; j < 16; j++) push(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 2'd0);
      e_error(2'd0, 2'b10, 0); e_error(2'd0, 2'b10, 1);
      e_idle(0); e_idle(0);
      run_seg();
      chk("timeout_invokes", n_inv, 1);
      chk("timeout_reads", n_rd, 0);

      // Loop: two back-to-back passes, loop dropped before the second capture.
      s_loop = 1; s_rin = 32'h0000_000A; s_sin = 32'h0000_0010;
      e_idle(1);
      e_pass(0, 3, 0);
      s_loop = 0; s_rin = 32'h0000_000B; s_sin = 32'h0000_0011;
      e_pass(0, 3, 0);
      e_idle(0); e_idle(0);
      run_seg();
      chk("loop_done", n_done, 2);
      chk("loop_result", result_q, 32'h0000_000B);
      chk("loop_count", 32'(pass_count), 4);

      // Spurious start/fc/clear while busy, fc on the invoke cycle, fc at earliest.
      s_rin = 32'h0000_0077; s_sin = 32'h0000_0003;
      e_idle(1);
      e_pass(2, 1, 1);
      e_idle(0); e_idle(0);
      run_seg();
      chk("robust_count", 32'(pass_count), 5);

      // Reset in WAIT_FC wins over a coincident fc and start.
      e_idle(1);
      e_check(2'd0, 1, 0);
      push(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 1, 0, 2'd0);
      push(1, 1, 0, 1, 1, 2'd0, 0, 0, 0, 1, 0, 2'd0);
      m_rq = 0; m_sq = 0; m_pc = 0;
      s_rin = 32'h0000_0099; s_sin = 32'h0000_0004;
      e_idle(0); e_idle(1);
      e_pass(0, 3, 0);
      e_idle(0); e_idle(0);
      run_seg();
      chk("after_reset_invokes", n_inv, 4);
      chk("after_reset_result", result_q, 32'h0000_0099);
      chk("after_reset_count", 32'(pass_count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
